// File: rtl/conv_encoder.sv
// conv_encoder -- rate-1/2, constraint-length-3 convolutional encoder.
//
// Accepts one information bit per handshake and emits one 2-bit coded symbol
// per handshake. Frames are FRAME_LEN information bits long. With
// CONV_ENC_TAIL_EN defined, each frame is followed by two zero tail bits so
// the downstream 4-state Viterbi trellis ends in state 0 (FRAME_LEN+2
// symbols). Without it, the last data symbol closes the frame (FRAME_LEN
// symbols).
//
// Build-time option: CONV_ENC_TAIL_EN (define to enable tail insertion).
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_start   one-cycle pulse starting a frame (honoured only when idle)
//   i_valid   upstream information bit valid
//   i_data    information bit
//   o_ready   encoder accepts i_data this cycle
//   o_valid   o_symbol valid
//   i_ready   downstream accepts o_symbol
//   o_symbol  coded symbol {c0,c1}; c0 from G0, c1 from G1
//   o_sof     first symbol of frame (qualified by o_valid)
//   o_eof     last symbol of frame (qualified by o_valid)
//   o_busy    frame in progress (DATA or TAIL)
//   o_done    pulse when the eof symbol is handed off
module conv_encoder #(
   parameter int          FRAME_LEN = 16,
   parameter logic [2:0]  G0        = 3'b111,
   parameter logic [2:0]  G1        = 3'b101
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic       i_valid,
   input  logic       i_data,
   output logic       o_ready,
   output logic       o_valid,
   input  logic       i_ready,
   output logic [1:0] o_symbol,
   output logic       o_sof,
   output logic       o_eof,
   output logic       o_busy,
   output logic       o_done
);

   localparam int CNT_W = $clog2(FRAME_LEN + 1);

   typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

   state_t             state, state_nxt;
   logic [1:0]         s;          // s[0] = previous bit, s[1] = bit before that
   logic [CNT_W-1:0]   bit_cnt;
   logic               sof_pend;   // next loaded symbol opens the frame
   logic               load_ok;
   logic               enc_en;
   logic               u;
   logic               eof_sym;
   logic               last_data;
`ifdef CONV_ENC_TAIL_EN
   logic               tail_cnt;   // 0 = first tail symbol, 1 = second
`endif

   // r = {u, s[0], s[1]}; symbol = {c0, c1}
   function automatic logic [1:0] encode(input logic bit_u, input logic [1:0] st);
      logic [2:0] r;
      r      = {bit_u, st[0], st[1]};
      encode = {^(r & G0), ^(r & G1)};
   endfunction

   assign load_ok   = !o_valid || i_ready;
   assign last_data = (bit_cnt == CNT_W'(FRAME_LEN - 1));
   assign o_busy    = (state != IDLE);
   assign o_done    = o_valid && i_ready && o_eof;

   always_comb begin
      state_nxt = state;
      o_ready   = 1'b0;
      enc_en    = 1'b0;
      u         = i_data;
      eof_sym   = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) state_nxt = DATA;
         end
         DATA: begin
            o_ready = load_ok;
            if (i_valid && load_ok) begin
               enc_en = 1'b1;
               if (last_data) begin
`ifdef CONV_ENC_TAIL_EN
                  state_nxt = TAIL;
`else
                  state_nxt = IDLE;
                  eof_sym   = 1'b1;
`endif
               end
            end
         end
`ifdef CONV_ENC_TAIL_EN
         TAIL: begin
            u = 1'b0;
            if (load_ok) begin
               enc_en = 1'b1;
               if (tail_cnt) begin
                  state_nxt = IDLE;
                  eof_sym   = 1'b1;
               end
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Control and encoder state
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         s        <= 2'b00;
         bit_cnt  <= '0;
         sof_pend <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
         tail_cnt <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (state == IDLE && i_start) begin
            s        <= 2'b00;
            bit_cnt  <= '0;
            sof_pend <= 1'b1;
`ifdef CONV_ENC_TAIL_EN
            tail_cnt <= 1'b0;
`endif
         end else if (enc_en) begin
            s        <= {s[0], u};
            sof_pend <= 1'b0;
            if (state == DATA)
               bit_cnt <= last_data ? '0 : bit_cnt + CNT_W'(1);
`ifdef CONV_ENC_TAIL_EN
            if (state == TAIL)
               tail_cnt <= ~tail_cnt;   // returns to 0 after the second tail bit
`endif
         end
      end
   end

   // Output register: loads whenever empty or being drained, holds under backpressure
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid  <= 1'b0;
         o_symbol <= 2'b00;
         o_sof    <= 1'b0;
         o_eof    <= 1'b0;
      end else if (enc_en) begin
         o_valid  <= 1'b1;
         o_symbol <= encode(u, s);
         o_sof    <= sof_pend;
         o_eof    <= eof_sym;
      end else if (i_ready) begin
         o_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder -- randomized self-checking bench for conv_encoder.
// Expected symbols come from a sliding-window model: symbol i depends on
// bits b[i], b[i-1], b[i-2] of the (tail-extended) frame, zero outside it.
module tb_conv_encoder;

   localparam int FL = 4;
`ifdef CONV_ENC_TAIL_EN
   localparam int TL = 2;
`else
   localparam int TL = 0;
`endif

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_start = 1'b0;
   logic       i_valid = 1'b0;
   logic       i_data = 1'b0;
   logic       o_ready;
   logic       o_valid;
   logic       i_ready = 1'b1;
   logic [1:0] o_symbol;
   logic       o_sof;
   logic       o_eof;
   logic       o_busy;
   logic       o_done;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic       fbits[FL];
   logic [3:0] exp_q[$];

   always #5 i_clk = ~i_clk;

   conv_encoder #(.FRAME_LEN(FL)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_start (i_start),
      .i_valid (i_valid),
      .i_data  (i_data),
      .o_ready (o_ready),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_symbol(o_symbol),
      .o_sof   (o_sof),
      .o_eof   (o_eof),
      .o_busy  (o_busy),
      .o_done  (o_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bits given msb-first: v[FL-1] is the first bit sent.
   task automatic set_bits(input logic [FL-1:0] v);
      for (int i = 0; i < FL; i++) fbits[i] = v[FL-1-i];
   endtask

   function automatic logic bit_at(input int i);
      if (i < 0 || i >= FL) return 1'b0;
      return fbits[i];
   endfunction

   // Expected entries: {c0, c1, sof, eof}
   task automatic build_expect();
      logic b0, b1, b2;
      exp_q.delete();
      for (int i = 0; i < FL + TL; i++) begin
         b0 = bit_at(i);
         b1 = bit_at(i - 1);
         b2 = bit_at(i - 2);
         exp_q.push_back({b0 ^ b1 ^ b2, b0 ^ b2, i == 0, i == FL + TL - 1});
      end
   endtask

   // gap_mode/bp_mode: 0 = always on, 1 = fixed pattern, 2 = random
   task automatic run_frame(input int gap_mode, input int bp_mode);
      int         bit_idx;
      int         cyc;
      logic       stalled;
      logic [3:0] held;
      logic [3:0] e;
      build_expect();
      bit_idx = 0;
      stalled = 1'b0;
      held    = '0;
      @(negedge i_clk);
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      check("busy_start", 32'(o_busy), 32'd1);
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 300) begin
         if (stalled) check("hold", 32'({o_symbol, o_sof, o_eof}), 32'(held));
         case (bp_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: i_ready = 1'($urandom_range(0, 1));
         endcase
         case (gap_mode)
            0:       i_valid = (bit_idx < FL);
            1:       i_valid = (bit_idx < FL) && (cyc % 2 == 1);
            default: i_valid = (bit_idx < FL) && ($urandom_range(0, 2) != 0);
         endcase
         i_data = i_valid ? fbits[bit_idx] : 1'($urandom_range(0, 1));
         #1;
         if (o_valid && !i_ready) check("ready_bp", 32'(o_ready), 32'd0);
         if (o_valid && i_ready) begin
            e = exp_q.pop_front();
            check("symbol", 32'({o_symbol, o_sof, o_eof}), 32'(e));
            check("done", 32'(o_done), 32'(e[0]));
         end else begin
            check("done_idle", 32'(o_done), 32'd0);
         end
         if (i_valid && o_ready) bit_idx++;
         stalled = o_valid && !i_ready;
         held    = {o_symbol, o_sof, o_eof};
         @(negedge i_clk);
         cyc++;
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      check("timeout", 32'(exp_q.size()), 32'd0);
      check("bits_taken", 32'(bit_idx), 32'(FL));
      check("busy_end", 32'(o_busy), 32'd0);
      check("valid_end", 32'(o_valid), 32'd0);
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_outs", 32'({o_symbol, o_sof, o_eof, o_done, o_busy, o_ready}), 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      set_bits(4'b1011); run_frame(0, 0);   // basic encode
      set_bits(4'b1011); run_frame(0, 1);   // backpressure pattern
      set_bits(4'b1011); run_frame(1, 0);   // upstream gaps
      set_bits(4'b0000); run_frame(0, 0);   // frame isolation
      for (int k = 0; k < 12; k++) begin
         set_bits(FL'($urandom));
         run_frame(2, 2);
      end

      // Reset mid-frame after two accepted bits
      @(negedge i_clk);
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      i_valid = 1'b1;
      i_data  = 1'b1;
      @(negedge i_clk);
      i_data  = 1'b0;
      @(negedge i_clk);
      i_valid = 1'b0;
      check("mid_valid_before", 32'(o_valid), 32'd1);
      #2 i_rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(o_valid), 32'd0);
      check("mid_rst_outs", 32'({o_symbol, o_sof, o_eof, o_done, o_busy, o_ready}), 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      set_bits(4'b1011); run_frame(0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/conv_encoder.md
Name: conv_encoder

Overview:
Rate-1/2, constraint-length-3 convolutional encoder. It is the transmit-side counterpart of the team's 4-state Viterbi decoder.
- Accepts one information bit per handshake and emits one 2-bit coded symbol per handshake.
- Frames are FRAME_LEN bits long. Each frame is terminated with K-1 zero tail bits, so the decoder trellis ends in state 0.
- Sits between the bit source and the channel/decoder input. The o_symbol ordering matches the decoder's 2-bit input.

Parameters:
FRAME_LEN, 16, information bits per frame (>=1)
G0, 3'b111, generator for o_symbol[1] (octal 7), bit2 = current input
G1, 3'b101, generator for o_symbol[0] (octal 5), bit2 = current input

Ports:
i_clk  in  1  clock, all logic rising-edge
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  one-cycle pulse; begins a frame, honoured only in IDLE
i_valid  in  1  upstream bit valid
i_data  in  1  information bit
o_ready  out  1  encoder accepts i_data this cycle
o_valid  out  1  o_symbol valid
i_ready  in  1  downstream accepts o_symbol
o_symbol  out  2  coded symbol {c0,c1}
o_sof  out  1  marks first symbol of frame (qualified by o_valid)
o_eof  out  1  marks last symbol of frame (qualified by o_valid)
o_busy  out  1  high in DATA or TAIL state
o_done  out  1  one-cycle pulse when o_eof symbol is handed off (o_valid & i_ready & o_eof)

Behaviour:
- Clock and reset: single clock i_clk; asynchronous active-low reset i_rst_n.
- Reset values:
  - state = IDLE; shift register s[1:0] = 0; bit counter = 0; TAIL counter = 0.
  - Outputs o_valid, o_symbol, o_sof, o_eof, o_done, o_busy, o_ready all 0.
- Reset mid-frame: the partial frame is discarded. No o_eof and no o_done are produced.
- Encoding:
  - Register vector r = {u, s[0], s[1]}.
  - c0 = ^(r & G0), c1 = ^(r & G1), o_symbol = {c0,c1}.
  - After each encode: s[1] <= s[0], s[0] <= u.
- Output register:
  - Single stage. Load occurs when o_valid==0 or i_ready==1.
  - Under backpressure (o_valid & !i_ready), o_symbol, o_sof and o_eof hold stable.
  - o_valid drops after handoff if nothing new is loaded.
- Latency and throughput:
  - A bit accepted at edge N appears on o_symbol after edge N (visible cycle N+1).
  - Throughput is 1 symbol/cycle with i_ready held high.
- State machine:
  - IDLE:
    - o_ready = 0.
    - i_start -> clear s, clear counters, go to DATA; the first loaded symbol carries o_sof = 1.
  - DATA:
    - o_ready = output register loadable.
    - Accept = i_valid & o_ready; increment bit counter on accept.
    - On the FRAME_LEN-th accept -> TAIL.
    - i_start is ignored.
  - TAIL:
    - o_ready = 0.
    - Internally encode u = 0 whenever the output register is loadable; two such loads occur.
    - The second tail symbol carries o_eof = 1 -> IDLE.
- Frame-boundary rules:
  - A new i_start in IDLE is legal while the eof symbol is still stalled. The new frame's first symbol waits for the output register.
  - FRAME_LEN = 1: o_sof and o_eof appear on different symbols (first data, last tail).
- Widths:
  - Bit counter width = $clog2(FRAME_LEN+1).
  - It wraps to 0 at frame end.
- After a complete frame, s = 2'b00.

Optional Feature:
CONV_ENC_TAIL_EN
- Defined: tail insertion as described; each frame produces FRAME_LEN+2 symbols.
- Undefined:
  - No TAIL state; DATA -> IDLE on the FRAME_LEN-th accept.
  - That data symbol carries o_eof; each frame produces FRAME_LEN symbols.
  - s is cleared only at i_start.

Test Plan:
- Basic encode (FRAME_LEN=4, tail on, i_ready=1): i_start, then bits 1,0,1,1 back-to-back.
  - o_symbol = 11,10,00,01,01,11 on consecutive cycles.
  - o_sof on the first symbol; o_eof and o_done on the sixth symbol.
- Backpressure: same frame with i_ready toggled 1,0,0,1,...
  - Symbol sequence unchanged; o_symbol holds while stalled.
  - o_ready = 0 whenever o_valid & !i_ready.
- Upstream gaps: i_valid low on alternating cycles -> identical symbol sequence; bit counter advances only on accepts.
- Frame isolation: second i_start immediately after o_done, bits 0,0,0,0.
  - Output 00 x6.
  - o_sof asserted again; no state leakage.
- Reset mid-frame: assert i_rst_n = 0 after 2 accepted bits.
  - Outputs go 0 asynchronously; state = IDLE.
  - The next frame 1,0,1,1 reproduces the basic-encode sequence.
- Tail disabled (CONV_ENC_TAIL_EN undefined): bits 1,0,1,1 -> 11,10,00,01; o_eof on 01; o_done the same cycle.
